// File: rtl/demux1x4_buf_if.sv
// ---------------------------------------------------------------------------
// demux1x4_buf_if
//   Bundles the producer and consumer side signals of the 1-to-4 buffered
//   demultiplexer.
//
//   in_data   [SIZE]   payload offered by the producer
//   in_sel    [2]      destination channel 0..3
//   in_valid  [1]      producer offers in_data/in_sel
//   in_ready  [1]      selected channel has room
//   out_data  [4*SIZE] channel k head word at out_data[k*SIZE +: SIZE]
//   out_valid [4]      bit k: channel k head word is valid
//   out_ready [4]      bit k: consumer k takes its head word
//   busy      [1]      OR of all out_valid bits
//
//   master : the environment (drives producer inputs and consumer readies)
//   slave  : the demultiplexer itself
// ---------------------------------------------------------------------------
interface demux1x4_buf_if #(
    parameter int SIZE = 8
);
    logic [SIZE-1:0]   in_data;
    logic [1:0]        in_sel;
    logic              in_valid;
    logic              in_ready;
    logic [4*SIZE-1:0] out_data;
    logic [3:0]        out_valid;
    logic [3:0]        out_ready;
    logic              busy;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, busy
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, busy
    );
endinterface

// File: rtl/demux1x4_buf.sv
// ---------------------------------------------------------------------------
// demux1x4_buf
//   Routes one input word stream to four output channels. Each channel owns a
//   private 2-entry FIFO so a stalled consumer only blocks pushes aimed at its
//   own channel. Output words come straight from registers.
//
//   clk    : clock, all state updates on the rising edge
//   rst_n  : asynchronous active-low reset, empties every channel and zeroes
//            the output data
//   bus    : demux1x4_buf_if.slave (producer handshake in, four consumer
//            handshakes out, busy flag)
// ---------------------------------------------------------------------------
module demux1x4_buf #(
    parameter int SIZE = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    demux1x4_buf_if.slave  bus
);

    logic [SIZE-1:0] r_mem  [4][2];
    logic [SIZE-1:0] r_dout [4];
    logic [3:0]      r_wptr;
    logic [3:0]      r_rptr;
    logic [1:0]      r_cnt  [4];

    logic [SIZE-1:0] w_mem_nxt  [4][2];
    logic [SIZE-1:0] w_dout_nxt [4];
    logic [3:0]      w_wptr_nxt;
    logic [3:0]      w_rptr_nxt;
    logic [1:0]      w_cnt_nxt  [4];

    logic            w_in_ready;
    logic            w_push;
    logic [3:0]      w_push_ch;
    logic [3:0]      w_pop;
    logic [3:0]      w_out_valid;

    // Ready depends only on the selected channel's occupancy; a full channel
    // refuses even if its consumer is popping this cycle.
    assign w_in_ready = (r_cnt[bus.in_sel] != 2'd2);
    assign w_push     = bus.in_valid && w_in_ready;

    always_comb begin
        w_mem_nxt  = r_mem;
        w_dout_nxt = r_dout;
        w_wptr_nxt = r_wptr;
        w_rptr_nxt = r_rptr;
        w_cnt_nxt  = r_cnt;
        w_push_ch  = '0;
        w_pop      = '0;
        for (int k = 0; k < 4; k++) begin
            w_push_ch[k] = w_push && (bus.in_sel == 2'(k));
            w_pop[k]     = (r_cnt[k] != 2'd0) && bus.out_ready[k];
            if (w_push_ch[k]) begin
                w_mem_nxt[k][r_wptr[k]] = bus.in_data;
                w_wptr_nxt[k]           = ~r_wptr[k];
            end
            if (w_pop[k]) begin
                w_rptr_nxt[k] = ~r_rptr[k];
            end
            case ({w_push_ch[k], w_pop[k]})
                2'b10:   w_cnt_nxt[k] = r_cnt[k] + 2'd1;
                2'b01:   w_cnt_nxt[k] = r_cnt[k] - 2'd1;
                default: w_cnt_nxt[k] = r_cnt[k];
            endcase
            // The output register tracks the next head; once the channel
            // drains it keeps the last delivered word.
            if (w_cnt_nxt[k] != 2'd0) begin
                w_dout_nxt[k] = w_mem_nxt[k][w_rptr_nxt[k]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int k = 0; k < 4; k++) begin
                r_cnt[k]    <= '0;
                r_dout[k]   <= '0;
                r_mem[k][0] <= '0;
                r_mem[k][1] <= '0;
            end
        end else begin
            r_wptr <= w_wptr_nxt;
            r_rptr <= w_rptr_nxt;
            r_cnt  <= w_cnt_nxt;
            r_dout <= w_dout_nxt;
            r_mem  <= w_mem_nxt;
        end
    end

    always_comb begin
        w_out_valid  = '0;
        bus.out_data = '0;
        for (int k = 0; k < 4; k++) begin
            w_out_valid[k]                 = (r_cnt[k] != 2'd0);
            bus.out_data[k*SIZE +: SIZE]   = r_dout[k];
        end
    end

    assign bus.out_valid = w_out_valid;
    assign bus.busy      = |w_out_valid;
    assign bus.in_ready  = w_in_ready;

endmodule
